fip_32_ray_tri_cramer: RTL and testbench

//  Ray-triangle intersection front end; consumes 3x3 determinants via Cramer's rule (Q16.16 signed, 32-bit).

---
 rtl/fip_32_pkg.sv | 41 ++++
 rtl/fip_32_3b3_det.sv | 49 ++++
 rtl/fip_32_ray_tri_cramer.sv | 183 ++++++++++++++++++
 tb/tb_fip_32_ray_tri_cramer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fip_32_pkg.sv
// Shared Q16.16 types, constants, FSM encoding and overflow-aware add/negate helpers
// for the fip_32 ray/triangle datapath.
package fip_32_pkg;

  typedef logic signed [2:0][31:0] vec3_t;

  localparam logic [31:0] FIP_ONE  = 32'h0001_0000;
  localparam logic [31:0] FIP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_DA   = 3'd2,
    S_DT   = 3'd3,
    S_DU   = 3'd4,
    S_DV   = 3'd5,
    S_EVAL = 3'd6,
    S_OUT  = 3'd7
  } cramer_state_e;

  typedef struct packed {
    logic               ovf;
    logic signed [31:0] val;
  } fip_res_t;

  // Overflow when operand signs differ and the result sign leaves the minuend's.
  function automatic fip_res_t fip_sub(input logic signed [31:0] a, input logic signed [31:0] b);
    fip_res_t r;
    r.val = a - b;
    r.ovf = (a[31] != b[31]) && (r.val[31] != a[31]);
    return r;
  endfunction

  function automatic fip_res_t fip_neg(input logic signed [31:0] a);
    fip_res_t r;
    r.val = -a;
    r.ovf = (a == 32'sh8000_0000);
    return r;
  endfunction

endpackage

// File: rtl/fip_32_3b3_det.sv
// Combinational 3x3 determinant of Q16.16 rows; exact wide products, floor back to Q16.16,
// overflow flagged when the result does not fit in 32 signed bits.
module fip_32_3b3_det
  import fip_32_pkg::*;
(
  input  vec3_t              i_r0,
  input  vec3_t              i_r1,
  input  vec3_t              i_r2,
  output logic signed [31:0] o_det,
  output logic               o_ovf
);

  logic signed [31:0] m [3][3];
  logic signed [63:0] p_ei, p_fh, p_di, p_fg, p_dh, p_eg;
  logic signed [64:0] c0, c1, c2;
  logic signed [96:0] t0, t1, t2;
  logic signed [98:0] acc;
  logic               unused_lsb;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      m[0][c] = $signed(i_r0[c]);
      m[1][c] = $signed(i_r1[c]);
      m[2][c] = $signed(i_r2[c]);
    end
  end

  // Cofactor expansion along row 0; Q48.48 accumulator is exact.
  always_comb begin
    p_ei = 64'(m[1][1]) * 64'(m[2][2]);
    p_fh = 64'(m[1][2]) * 64'(m[2][1]);
    p_di = 64'(m[1][0]) * 64'(m[2][2]);
    p_fg = 64'(m[1][2]) * 64'(m[2][0]);
    p_dh = 64'(m[1][0]) * 64'(m[2][1]);
    p_eg = 64'(m[1][1]) * 64'(m[2][0]);
    c0   = 65'(p_ei) - 65'(p_fh);
    c1   = 65'(p_di) - 65'(p_fg);
    c2   = 65'(p_dh) - 65'(p_eg);
    t0   = 97'(m[0][0]) * 97'(c0);
    t1   = 97'(m[0][1]) * 97'(c1);
    t2   = 97'(m[0][2]) * 97'(c2);
    acc  = 99'(t0) - 99'(t1) + 99'(t2);
  end

  assign o_det      = acc[63:32];
  assign o_ovf      = !((acc[98:63] == '0) || (acc[98:63] == '1));
  assign unused_lsb = ^acc[31:0];

endmodule

// File: rtl/fip_32_ray_tri_cramer.sv
// Ray/triangle Cramer front end: one shared 3x3 determinant unit walked through detA, detT,
// detU, detV, then a division-free inside/ahead test. Handshakes on both sides are
// valid/ready: a transfer happens on a clock edge where valid and ready are both high.
module fip_32_ray_tri_cramer
  import fip_32_pkg::*;
#(
  parameter int          TAG_W = 16,
  parameter logic [31:0] EPS   = 32'd0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  vec3_t              i_orig,
  input  vec3_t              i_dir,
  input  vec3_t              i_v0,
  input  vec3_t              i_v1,
  input  vec3_t              i_v2,
  input  logic [TAG_W-1:0]   i_tri_id,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_hit,
  output logic signed [31:0] o_det_a,
  output logic signed [31:0] o_det_t,
  output logic signed [31:0] o_det_u,
  output logic signed [31:0] o_det_v,
  output logic [TAG_W-1:0]   o_tri_id,
  output logic               o_overflow,
  output cramer_state_e      o_dbg_state
);

  cramer_state_e      state, state_n;
  vec3_t              orig_q, dir_q, v0_q, v1_q, v2_q;
  vec3_t              e1_q, e2_q, t_q, nd_q;
  vec3_t              e1_c, e2_c, t_c, nd_c;
  fip_res_t           r_e1 [3], r_e2 [3], r_t [3], r_nd [3];
  logic               prep_ovf, ovf_q, det_ovf, parallel, hit_c;
  vec3_t              row0, row1, row2;
  logic signed [31:0] det_res;
  logic [32:0]        det_mag;
  logic signed [33:0] eps_s, mag_s, st_s, su_s, sv_s, suv_s;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (i_valid) state_n = S_PREP;
      S_PREP:  state_n = S_DA;
      S_DA:    state_n = parallel ? S_EVAL : S_DT;
      S_DT:    state_n = S_DU;
      S_DU:    state_n = S_DV;
      S_DV:    state_n = S_EVAL;
      S_EVAL:  state_n = S_OUT;
      S_OUT:   if (i_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    prep_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_e1[i] = fip_sub(v1_q[i], v0_q[i]);
      r_e2[i] = fip_sub(v2_q[i], v0_q[i]);
      r_t[i]  = fip_sub(orig_q[i], v0_q[i]);
      r_nd[i] = fip_neg(dir_q[i]);
      e1_c[i] = r_e1[i].val;
      e2_c[i] = r_e2[i].val;
      t_c[i]  = r_t[i].val;
      nd_c[i] = r_nd[i].val;
      prep_ovf = prep_ovf | r_e1[i].ovf | r_e2[i].ovf | r_t[i].ovf | r_nd[i].ovf;
    end
  end

  // Each later matrix is |-D;E1;E2| with one row swapped for T.
  always_comb begin
    row0 = nd_q;
    row1 = e1_q;
    row2 = e2_q;
    case (state)
      S_DT:    row0 = t_q;
      S_DU:    row1 = t_q;
      S_DV:    row2 = t_q;
      default: ;
    endcase
  end

  fip_32_3b3_det u_det (
    .i_r0  (row0),
    .i_r1  (row1),
    .i_r2  (row2),
    .o_det (det_res),
    .o_ovf (det_ovf)
  );

  assign det_mag  = det_res[31] ? (33'd0 - {1'b1, det_res}) : {1'b0, det_res};
  assign parallel = (det_mag <= {1'b0, EPS});

  // Multiplying by sign(detA) keeps t/u/v tests free of division; 34 bits avoid wrap.
  always_comb begin
    eps_s = $signed({2'b00, EPS});
    mag_s = o_det_a[31] ? -34'(o_det_a) : 34'(o_det_a);
    st_s  = o_det_a[31] ? -34'(o_det_t) : 34'(o_det_t);
    su_s  = o_det_a[31] ? -34'(o_det_u) : 34'(o_det_u);
    sv_s  = o_det_a[31] ? -34'(o_det_v) : 34'(o_det_v);
    suv_s = 34'(o_det_u) + 34'(o_det_v);
    if (o_det_a[31]) suv_s = -suv_s;
    hit_c = !ovf_q && (mag_s > eps_s) && (st_s > 34'sd0) && (su_s >= 34'sd0) &&
            (sv_s >= 34'sd0) && (suv_s <= mag_s);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      orig_q   <= '0;
      dir_q    <= '0;
      v0_q     <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      e1_q     <= '0;
      e2_q     <= '0;
      t_q      <= '0;
      nd_q     <= '0;
      ovf_q    <= 1'b0;
      o_hit    <= 1'b0;
      o_det_a  <= '0;
      o_det_t  <= '0;
      o_det_u  <= '0;
      o_det_v  <= '0;
      o_tri_id <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_valid) begin
          orig_q   <= i_orig;
          dir_q    <= i_dir;
          v0_q     <= i_v0;
          v1_q     <= i_v1;
          v2_q     <= i_v2;
          o_tri_id <= i_tri_id;
          ovf_q    <= 1'b0;
          o_hit    <= 1'b0;
          o_det_a  <= '0;
          o_det_t  <= '0;
          o_det_u  <= '0;
          o_det_v  <= '0;
        end
        S_PREP: begin
          e1_q  <= e1_c;
          e2_q  <= e2_c;
          t_q   <= t_c;
          nd_q  <= nd_c;
          ovf_q <= ovf_q | prep_ovf;
        end
        S_DA: begin
          o_det_a <= det_res;
          ovf_q   <= ovf_q | det_ovf;
        end
        S_DT: begin
          o_det_t <= det_res;
          ovf_q   <= ovf_q | det_ovf;
        end
        S_DU: begin
          o_det_u <= det_res;
          ovf_q   <= ovf_q | det_ovf;
        end
        S_DV: begin
          o_det_v <= det_res;
          ovf_q   <= ovf_q | det_ovf;
        end
        S_EVAL:  o_hit <= hit_c;
        default: ;
      endcase
    end
  end

  assign o_ready     = (state == S_IDLE);
  assign o_valid     = (state == S_OUT);
  assign o_overflow  = ovf_q;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_fip_32_ray_tri_cramer.sv
// Bench for fip_32_ray_tri_cramer: directed geometry cases, backpressure, mid-flight reset,
// and randomized rays checked against an exact-arithmetic Cramer model.
module tb_fip_32_ray_tri_cramer;
  import fip_32_pkg::*;

  localparam int          TAG_W = 16;
  localparam logic [31:0] EPS   = 32'd0;

  typedef struct packed {
    logic        hit;
    logic        ovf;
    logic [31:0] a;
    logic [31:0] t;
    logic [31:0] u;
    logic [31:0] v;
    logic [15:0] id;
    logic [31:0] lat;
    logic [31:0] acc_cyc;
  } exp_t;

  logic             i_clk, i_rstn, i_valid, o_ready, o_valid, i_ready;
  vec3_t            i_orig, i_dir, i_v0, i_v1, i_v2;
  logic [TAG_W-1:0] i_tri_id, o_tri_id;
  logic             o_hit, o_overflow;
  logic [31:0]      o_det_a, o_det_t, o_det_u, o_det_v;
  cramer_state_e    dbg_state;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic seen_first = 1'b0;
  logic rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  fip_32_ray_tri_cramer #(.TAG_W(TAG_W), .EPS(EPS)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_orig(i_orig), .i_dir(i_dir), .i_v0(i_v0), .i_v1(i_v1), .i_v2(i_v2),
    .i_tri_id(i_tri_id), .o_valid(o_valid), .i_ready(i_ready), .o_hit(o_hit),
    .o_det_a(o_det_a), .o_det_t(o_det_t), .o_det_u(o_det_u), .o_det_v(o_det_v),
    .o_tri_id(o_tri_id), .o_overflow(o_overflow), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset / ready ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic vec3_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  function automatic logic out32(input longint x);
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  function automatic logic signed [127:0] w(input vec3_t r, input int i);
    logic signed [31:0] s;
    s = $signed(r[i]);
    return 128'(s);
  endfunction

  // Exact determinant by the rule of Sarrus, floored back to Q16.16.
  function automatic void mdet(input vec3_t r0, input vec3_t r1, input vec3_t r2,
                               output logic [31:0] val, output logic ovf);
    logic signed [127:0] full, q;
    full = w(r0,0)*w(r1,1)*w(r2,2) + w(r0,1)*w(r1,2)*w(r2,0) + w(r0,2)*w(r1,0)*w(r2,1)
         - w(r0,2)*w(r1,1)*w(r2,0) - w(r0,1)*w(r1,0)*w(r2,2) - w(r0,0)*w(r1,2)*w(r2,1);
    q    = full >>> 32;
    ovf  = (q > 128'sd2147483647) || (q < -128'sd2147483648);
    val  = q[31:0];
  endfunction

  function automatic exp_t model(input vec3_t o, input vec3_t d, input vec3_t v0,
                                 input vec3_t v1, input vec3_t v2, input logic [15:0] id);
    exp_t e;
    vec3_t e1, e2, tt, nd;
    logic ovf, od;
    longint x, la, lt, lu, lv, s, mag;
    e   = '0;
    ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = longint'($signed(v1[i])) - longint'($signed(v0[i])); ovf |= out32(x); e1[i] = x[31:0];
      x = longint'($signed(v2[i])) - longint'($signed(v0[i])); ovf |= out32(x); e2[i] = x[31:0];
      x = longint'($signed(o[i]))  - longint'($signed(v0[i])); ovf |= out32(x); tt[i] = x[31:0];
      x = -longint'($signed(d[i]));                             ovf |= out32(x); nd[i] = x[31:0];
    end
    e.id = id;
    mdet(nd, e1, e2, e.a, od); ovf |= od;
    la  = longint'($signed(e.a));
    mag = (la < 0) ? -la : la;
    if (mag <= longint'(EPS)) begin
      e.lat = 3;
      e.ovf = ovf;
      e.hit = 1'b0;
    end else begin
      mdet(tt, e1, e2, e.t, od); ovf |= od;
      mdet(nd, tt, e2, e.u, od); ovf |= od;
      mdet(nd, e1, tt, e.v, od); ovf |= od;
      lt = longint'($signed(e.t));
      lu = longint'($signed(e.u));
      lv = longint'($signed(e.v));
      s  = (la < 0) ? -1 : 1;
      e.lat = 6;
      e.ovf = ovf;
      e.hit = !ovf && (s*lt > 0) && (s*lu >= 0) && (s*lv >= 0) && (s*(lu+lv) <= mag);
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input vec3_t o, input vec3_t d, input vec3_t v0, input vec3_t v1,
                      input vec3_t v2, input logic [15:0] id, output exp_t e);
    int n;
    e = model(o, d, v0, v1, v2, id);
    @(negedge i_clk);
    i_orig = o; i_dir = d; i_v0 = v0; i_v1 = v1; i_v2 = v2; i_tri_id = id;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 60) begin
      @(negedge i_clk);
      n++;
    end
    check("accept_timeout", 64'(o_ready), 64'd1);
    if (o_ready) begin
      e.acc_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    seen_first = 1'b0;
  endtask

  function automatic logic [31:0] rq();
    logic [31:0] r;
    r = $urandom_range(0, 32'h40000);
    return r - 32'h20000;
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge i_clk) begin
    if (i_rstn && o_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(o_valid), 64'd0);
      end else begin
        if (!seen_first) begin
          check("latency", 64'(cyc - int'(exp_q[0].acc_cyc)), 64'(exp_q[0].lat));
          seen_first = 1'b1;
        end
        check("det_a", 64'(o_det_a), 64'(exp_q[0].a));
        check("det_t", 64'(o_det_t), 64'(exp_q[0].t));
        check("det_u", 64'(o_det_u), 64'(exp_q[0].u));
        check("det_v", 64'(o_det_v), 64'(exp_q[0].v));
        check("hit", 64'(o_hit), 64'(exp_q[0].hit));
        check("overflow", 64'(o_overflow), 64'(exp_q[0].ovf));
        check("tri_id", 64'(o_tri_id), 64'(exp_q[0].id));
        check("ready_while_valid", 64'(o_ready), 64'd0);
        if (i_ready) begin
          void'(exp_q.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t  e;
    vec3_t o, d, v0, v1, v2;
    int    n, mode;
    logic [31:0] q1, q4, q34;
    q1  = FIP_ONE;
    q4  = 32'h0000_4000;
    q34 = 32'h0000_C000;
    i_rstn = 1'b0; i_valid = 1'b0; i_tri_id = '0;
    i_orig = '0; i_dir = '0; i_v0 = '0; i_v1 = '0; i_v2 = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_hit", 64'(o_hit), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    check("rst_dets", {o_det_a ^ o_det_t, o_det_u | o_det_v}, 64'd0);
    check("rst_id", 64'(o_tri_id), 64'd0);
    i_rstn = 1'b1;

    v0 = mk(0, 0, 0); v1 = mk(q1, 0, 0); v2 = mk(0, q1, 0);

    // 1: straight-down hit at (.25,.25)
    send(mk(q4, q4, q1), mk(0, 0, -q1), v0, v1, v2, 16'h0001, e);
    check("m1_hit", 64'(e.hit), 64'd1);
    check("m1_a", 64'(e.a), 64'h10000);
    check("m1_t", 64'(e.t), 64'h10000);
    check("m1_uv", {e.u, e.v}, {32'h4000, 32'h4000});
    check("m1_ovf", 64'(e.ovf), 64'd0);
    wait_drain();

    // 2: outside the hypotenuse
    send(mk(q34, q34, q1), mk(0, 0, -q1), v0, v1, v2, 16'h0002, e);
    check("m2_hit", 64'(e.hit), 64'd0);
    check("m2_uv", {e.u, e.v}, {32'hC000, 32'hC000});
    check("m2_a", 64'(e.a), 64'h10000);
    wait_drain();

    // 3: ray parallel to the triangle plane
    send(mk(q4, q4, q1), mk(q1, 0, 0), v0, v1, v2, 16'h0003, e);
    check("m3_a", 64'(e.a), 64'd0);
    check("m3_lat", 64'(e.lat), 64'd3);
    check("m3_tuv", {e.t | e.u | e.v, 31'd0, e.hit}, 64'd0);
    wait_drain();

    // 4: triangle behind the ray
    send(mk(q4, q4, q1), mk(0, 0, q1), v0, v1, v2, 16'h0004, e);
    check("m4_a", 64'(e.a), 64'hFFFF0000);
    check("m4_t", 64'(e.t), 64'h10000);
    check("m4_hit", 64'(e.hit), 64'd0);
    wait_drain();

    // 5: edge subtraction overflows
    send(mk(q4, q4, q1), mk(0, 0, -q1), mk(-(32'd30000 << 16), 0, 0),
         mk(32'd30000 << 16, 0, 0), v2, 16'h0005, e);
    check("m5_ovf", 64'(e.ovf), 64'd1);
    check("m5_hit", 64'(e.hit), 64'd0);
    wait_drain();

    // 6a: backpressure with ignored new input
    rdy_force = 1'b0;
    @(negedge i_clk);
    send(mk(q4, q4, q1), mk(0, 0, -q1), v0, v1, v2, 16'h0006, e);
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("hold_valid_seen", 64'(o_valid), 64'd1);
    i_orig = mk(q34, q34, q1); i_tri_id = 16'h0BAD; i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_ready", 64'(o_ready), 64'd0);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    rdy_force = 1'b1;
    wait_drain();
    repeat (10) @(negedge i_clk);
    check("hold_no_accept", 64'(dbg_state), 64'(S_IDLE));

    // 6b: reset while detU is being formed
    send(mk(q4, q4, q1), mk(0, 0, -q1), v0, v1, v2, 16'h0007, e);
    n = 0;
    while (dbg_state != S_DU && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    check("reach_du", 64'(dbg_state), 64'(S_DU));
    i_rstn = 1'b0;
    exp_q.delete();
    seen_first = 1'b0;
    #1;
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_dets", {o_det_a | o_det_t, o_det_u | o_det_v}, 64'd0);
    check("abort_flags", {o_tri_id, o_hit, o_overflow}, 64'd0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    #1;
    check("abort_ready", 64'(o_ready), 64'd1);
    repeat (12) @(negedge i_clk);

    // randomized traffic with random downstream stalls
    rdy_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      mode = $urandom_range(0, 3);
      o = mk(rq(), rq(), rq()); d = mk(rq(), rq(), rq());
      v0 = mk(rq(), rq(), rq()); v1 = mk(rq(), rq(), rq()); v2 = mk(rq(), rq(), rq());
      case (mode)
        1: begin
          v0 = mk(rq(), rq(), 0); v1 = mk(rq(), rq(), 0); v2 = mk(rq(), rq(), 0);
          o = mk(rq(), rq(), q1); d = mk(0, 0, -q1);
        end
        2: d = mk(0, 0, 0);
        3: v1 = mk($urandom, $urandom, $urandom);
        default: ;
      endcase
      send(o, d, v0, v1, v2, 16'($urandom), e);
    end
    wait_drain();
    rdy_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
